// File: rtl/timer_pkg.sv
// Shared encodings for the APB timer count stage: clock-select, direction and run/stop state.
// The optional one-shot mode (macro TIMER_ONESHOT_EN) uses run_state_t.
package timer_pkg;

    localparam int TIMER_WIDTH = 8;
    localparam int TIMER_PSC_W = 4;

    localparam logic [1:0] CKS_DIV2  = 2'b00;
    localparam logic [1:0] CKS_DIV4  = 2'b01;
    localparam logic [1:0] CKS_DIV8  = 2'b10;
    localparam logic [1:0] CKS_DIV16 = 2'b11;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    typedef enum logic {
        RUN  = 1'b0,
        STOP = 1'b1
    } run_state_t;

endpackage

// File: rtl/timer_prescaler.sv
// Free-running prescaler; term flags the last PCLK of each 2^(cks+1) period.
// clr restarts the count regardless of en.
module timer_prescaler
    import timer_pkg::*;
#(
    parameter int PSC_W = TIMER_PSC_W
) (
    input  logic       PCLK,
    input  logic       PRESETn,
    input  logic       en,
    input  logic       clr,
    input  logic [1:0] cks,
    output logic       term
);

    logic [PSC_W-1:0] psc;
    logic [PSC_W-1:0] mask;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            psc <= '0;
        end else if (clr) begin
            psc <= '0;
        end else if (en) begin
            psc <= psc + PSC_W'(1);
        end
    end

    // Low cks+1 bits set; the upper bits keep counting through terminal.
    always_comb begin
        mask = '0;
        for (int i = 0; i < PSC_W; i++) begin
            mask[i] = (i <= int'(cks));
        end
    end

    assign term = ((psc & mask) == mask);

endmodule

// File: rtl/timer_counter.sv
// Count stage of the APB 8-bit timer: prescaled stepping of TCNT with load, tick and wrap.
// Defining TIMER_ONESHOT_EN adds the oneshot input and a RUN/STOP FSM that halts on wrap.
module timer_counter
    import timer_pkg::*;
#(
    parameter int WIDTH = TIMER_WIDTH,
    parameter int PSC_W = TIMER_PSC_W
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    input  logic             en,
    input  logic             up_down,
    input  logic [1:0]       cks,
    input  logic             load,
    input  logic [WIDTH-1:0] TDR,
`ifdef TIMER_ONESHOT_EN
    input  logic             oneshot,
`endif
    output logic [WIDTH-1:0] TCNT,
    output logic             tick,
    output logic             wrap
);

    logic term;
    logic run;
    logic step;
    logic at_limit;

    timer_prescaler #(.PSC_W(PSC_W)) u_prescaler (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .en      (en),
        .clr     (load),
        .cks     (cks),
        .term    (term)
    );

    assign at_limit = (up_down == DIR_UP) ? (TCNT == '1) : (TCNT == '0);
    // load pre-empts a step landing on the same edge.
    assign step     = en && term && run && !load;

`ifdef TIMER_ONESHOT_EN
    run_state_t state_q;
    run_state_t state_d;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (step && at_limit && oneshot) state_d = STOP;
            STOP:    if (load || !en)                 state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        run = (state_q == RUN);
    end
`else
    assign run = 1'b1;
`endif

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            TCNT <= '0;
            tick <= 1'b0;
            wrap <= 1'b0;
        end else if (load) begin
            TCNT <= TDR;
            tick <= 1'b0;
            wrap <= 1'b0;
        end else if (step) begin
            TCNT <= (up_down == DIR_UP) ? TCNT + WIDTH'(1) : TCNT - WIDTH'(1);
            tick <= 1'b1;
            wrap <= at_limit;
        end else begin
            tick <= 1'b0;
            wrap <= 1'b0;
        end
    end

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter; each tick pops an expected {wrap, TCNT} from the scoreboard.
// Define TIMER_ONESHOT_EN to also exercise the one-shot stop/resume behaviour.
module tb_timer_counter;

    localparam int W = 8;

    logic         PCLK;
    logic         PRESETn;
    logic         en;
    logic         up_down;
    logic [1:0]   cks;
    logic         load;
    logic [W-1:0] TDR;
    logic [W-1:0] TCNT;
    logic         tick;
    logic         wrap;
`ifdef TIMER_ONESHOT_EN
    logic         oneshot;
`endif

    logic [W:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    logic prev_tick = 1'b0;

    timer_counter dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .en      (en),
        .up_down (up_down),
        .cks     (cks),
        .load    (load),
        .TDR     (TDR),
`ifdef TIMER_ONESHOT_EN
        .oneshot (oneshot),
`endif
        .TCNT    (TCNT),
        .tick    (tick),
        .wrap    (wrap)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge PCLK);
    endtask

    task automatic do_load(input logic [W-1:0] val);
        TDR  = val;
        load = 1'b1;
        @(negedge PCLK);
        load = 1'b0;
    endtask

    task automatic push(input logic w, input logic [W-1:0] v);
        exp_q.push_back({w, v});
    endtask

    // Scoreboard: every tick must match the next expected step; wrap only ever rides a tick.
    always @(negedge PCLK) begin
        if (tick) begin
            check("tick_width", {31'b0, prev_tick}, 32'd0);
            if (exp_q.size() == 0) begin
                check("tick_unexpected", {31'b0, tick}, 32'd0);
            end else begin
                logic [W:0] e;
                e = exp_q.pop_front();
                check("step_value", {23'b0, wrap, TCNT}, {23'b0, e});
            end
        end else if (wrap) begin
            check("wrap_without_tick", {31'b0, wrap}, 32'd0);
        end
        prev_tick = tick;
    end

    initial begin
        PRESETn = 1'b0;
        en      = 1'b0;
        up_down = 1'b0;
        cks     = 2'b00;
        load    = 1'b0;
        TDR     = '0;
`ifdef TIMER_ONESHOT_EN
        oneshot = 1'b0;
`endif
        cycles(3);
        check("reset_tcnt", {24'b0, TCNT}, 32'h0);
        check("reset_tick", {31'b0, tick}, 32'h0);
        check("reset_wrap", {31'b0, wrap}, 32'h0);
        PRESETn = 1'b1;

        // Reset mid-count: /2 steps on edges 2,4,6,8,10.
        en = 1'b1;
        for (int i = 1; i <= 5; i++) push(1'b0, W'(i));
        cycles(10);
        check("midcount_tcnt", {24'b0, TCNT}, 32'h5);
        #2 PRESETn = 1'b0;
        #1;
        check("async_rst_tcnt", {24'b0, TCNT}, 32'h0);
        check("async_rst_tick", {31'b0, tick}, 32'h0);
        @(negedge PCLK);
        PRESETn = 1'b1;
        cycles(1);
        check("post_rst_tcnt", {24'b0, TCNT}, 32'h0);
        check("post_rst_tick", {31'b0, tick}, 32'h0);
        en = 1'b0;

        // Divide by 8 from 0x10: ten steps in 80 PCLK.
        up_down = 1'b0;
        cks     = 2'b10;
        en      = 1'b1;
        for (int i = 1; i <= 10; i++) push(1'b0, W'(8'h10 + i));
        do_load(8'h10);
        cycles(7);
        check("div8_early", {24'b0, TCNT}, 32'h10);
        cycles(73);
        check("div8_tcnt", {24'b0, TCNT}, 32'h1A);
        en = 1'b0;

        // Up wrap.
        do_load(8'hFE);
        cks = 2'b00;
        en  = 1'b1;
        push(1'b0, 8'hFF);
        push(1'b1, 8'h00);
        cycles(2);
        check("upwrap_ff", {24'b0, TCNT}, 32'hFF);
        cycles(2);
        check("upwrap_00", {24'b0, TCNT}, 32'h00);
        check("upwrap_flag", {31'b0, wrap}, 32'h1);
        cycles(1);
        check("upwrap_flag_gone", {31'b0, wrap}, 32'h0);
        en = 1'b0;

        // Down wrap.
        do_load(8'h01);
        up_down = 1'b1;
        en      = 1'b1;
        push(1'b0, 8'h00);
        push(1'b1, 8'hFF);
        cycles(2);
        check("downwrap_00", {24'b0, TCNT}, 32'h00);
        cycles(2);
        check("downwrap_ff", {24'b0, TCNT}, 32'hFF);
        en = 1'b0;

        // Load on the terminal cycle wins and restarts the prescaler.
        up_down = 1'b0;
        do_load(8'h20);
        en = 1'b1;
        cycles(1);
        do_load(8'h55);
        check("ldprio_tcnt", {24'b0, TCNT}, 32'h55);
        check("ldprio_tick", {31'b0, tick}, 32'h0);
        push(1'b0, 8'h56);
        cycles(1);
        check("ldprio_hold", {24'b0, TCNT}, 32'h55);
        cycles(1);
        check("ldprio_next", {24'b0, TCNT}, 32'h56);
        en = 1'b0;

`ifdef TIMER_ONESHOT_EN
        oneshot = 1'b1;
        do_load(8'hFD);
        en = 1'b1;
        push(1'b0, 8'hFE);
        push(1'b0, 8'hFF);
        push(1'b1, 8'h00);
        cycles(6);
        check("oneshot_stop", {24'b0, TCNT}, 32'h00);
        cycles(8);
        check("oneshot_hold", {24'b0, TCNT}, 32'h00);
        push(1'b0, 8'h11);
        do_load(8'h10);
        cycles(2);
        check("oneshot_resume", {24'b0, TCNT}, 32'h11);
        en = 1'b0;
        oneshot = 1'b0;
`endif

        cycles(4);
        check("sb_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
